// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the simulation run controller: FSM state encoding.
package sim_ctrl_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_RESET   = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_t;

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the 2nd clock edge.
module reset_sync (
  input  logic clk,
  input  logic reset,
  output logic rst_s
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta  <= 1'b1;
      rst_s <= 1'b1;
    end else begin
      meta  <= 1'b0;
      rst_s <= meta;
    end
  end

endmodule

// File: rtl/sim_run_controller.sv
// Run controller for the CPU top level: staggered core resets, run-cycle counter,
// progress watchdog and a sticky DONE / TIMEOUT verdict.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RESET   | internal reset active, all channels held in reset
// ST_HOLD    | reset released internally, waiting for channel 0 release
// ST_RELEASE | channels being released one by one
// ST_RUN     | all channels released, counting cycles, watchdog armed
// ST_DONE    | core halted, terminal until reset
// ST_TIMEOUT | watchdog expired, terminal until reset
module sim_run_controller
  import sim_ctrl_pkg::*;
#(
  parameter int NUM_CHANNELS   = 2,
  parameter int RESET_HOLD     = 2,
  parameter int STAGGER        = 1,
  parameter int TIMEOUT_CYCLES = 500,
  parameter int CNT_W          = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    halt_i,
  input  logic                    kick_i,
  output logic [NUM_CHANNELS-1:0] core_reset,
  output logic [ST_W-1:0]         state_o,
  output logic [CNT_W-1:0]        cycle_count,
  output logic                    done,
  output logic                    timeout
);

  localparam int LAST_REL = RESET_HOLD + (NUM_CHANNELS - 1) * STAGGER;
  localparam int PH_W     = $clog2(LAST_REL + 2);

  localparam logic [PH_W-1:0]  PH_CH0  = PH_W'(RESET_HOLD);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(LAST_REL);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8) begin : g_bad_channels
    $error("sim_run_controller: NUM_CHANNELS must be 1..8");
  end
  if (RESET_HOLD < 1) begin : g_bad_hold
    $error("sim_run_controller: RESET_HOLD must be >= 1");
  end
  if (STAGGER < 0) begin : g_bad_stagger
    $error("sim_run_controller: STAGGER must be >= 0");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("sim_run_controller: TIMEOUT_CYCLES must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("sim_run_controller: CNT_W must be >= 1");
  end

  logic                    rst_s;
  state_t                  state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d, phase_inc;
  logic [NUM_CHANNELS-1:0] rel_mask, core_reset_d;
  logic [CNT_W-1:0]        cnt_d, wd_q, wd_d;
  logic                    done_d, timeout_d;

  reset_sync u_reset_sync (
    .clk   (clk),
    .reset (reset),
    .rst_s (rst_s)
  );

  // phase_inc is the edge count since t0 that the upcoming edge will reach
  assign phase_inc = phase_q + PH_W'(1);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_rel
    assign rel_mask[i] = (phase_inc >= PH_W'(RESET_HOLD + i * STAGGER));
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    core_reset_d = core_reset;
    cnt_d        = cycle_count;
    wd_d         = wd_q;
    done_d       = done;
    timeout_d    = timeout;
    case (state_q)
      ST_RESET: begin
        core_reset_d = '1;
        phase_d      = '0;
        cnt_d        = '0;
        wd_d         = '0;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        if (!rst_s) state_d = ST_HOLD;
      end
      ST_HOLD, ST_RELEASE: begin
        phase_d      = phase_inc;
        core_reset_d = ~rel_mask;
        if (phase_inc >= PH_LAST)     state_d = ST_RUN;
        else if (phase_inc >= PH_CH0) state_d = ST_RELEASE;
      end
      ST_RUN: begin
        if (cycle_count != '1) cnt_d = cycle_count + CNT_W'(1);
        // halt takes precedence over a watchdog expiry on the same edge
        if (halt_i) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (wd_q == WD_LAST && !kick_i) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
        end else if (kick_i) begin
          wd_d = '0;
        end else begin
          wd_d = wd_q + CNT_W'(1);
        end
      end
      ST_DONE, ST_TIMEOUT: begin
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RESET;
      phase_q     <= '0;
      core_reset  <= '1;
      cycle_count <= '0;
      wd_q        <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      core_reset  <= core_reset_d;
      cycle_count <= cnt_d;
      wd_q        <= wd_d;
      done        <= done_d;
      timeout     <= timeout_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: doc/sim_run_controller.md
Name: sim_run_controller

Overview:
Synthesizable run controller for the multi-cycle RISC-V CPU top level. It takes over the ad-hoc reset pulse and fixed-time stop from the bench:
- generates staggered per-channel core resets from one raw reset;
- counts run cycles;
- runs a progress watchdog fed by the core's retire/kick signal;
- reports a terminal DONE (core halted) or TIMEOUT status.

A bench or FPGA wrapper sits above it; `core_reset` drives the DUT channels (CPU, memories, peripherals).

Parameters:
- NUM_CHANNELS, 2, number of independently released reset outputs (1..8)
- RESET_HOLD, 2, cycles all channels stay in reset after internal reset release (>=1)
- STAGGER, 1, extra cycles between release of channel i and channel i+1 (>=0)
- TIMEOUT_CYCLES, 500, consecutive RUN cycles without kick before TIMEOUT (>=1)
- CNT_W, 32, width of cycle counter and watchdog counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  raw reset, asynchronous, active-high
- halt_i  in  1  core halt/ebreak indication, level, sampled in RUN only
- kick_i  in  1  progress pulse (instruction retire), sampled in RUN only
- core_reset  out  NUM_CHANNELS  per-channel active-high reset to DUT blocks
- state_o  out  3  current FSM state encoding
- cycle_count  out  CNT_W  cycles spent in RUN
- done  out  1  core halted normally (sticky until reset)
- timeout  out  1  watchdog expired (sticky until reset)

Behaviour:
- Reset strategy:
  - One clock `clk`; reset is asynchronous and active-high on port `reset`.
  - Assertion is immediate to all flops.
  - Deassertion passes through a 2-flop synchroniser; internal `rst_s` falls on the 2nd rising edge after `reset` falls.
- Reset values: `core_reset` all 1; `state_o` = RESET; `cycle_count` = 0; `done` = 0; `timeout` = 0; watchdog and hold counters = 0.
- States (encoding): RESET=0, HOLD=1, RELEASE=2, RUN=3, DONE=4, TIMEOUT=5. Values 6 and 7 are unused and recover to RESET.
- RESET -> HOLD: on the first edge with `rst_s`=0. Call that edge t0.
- HOLD/RELEASE timing:
  - A phase counter counts edges from t0.
  - `core_reset[i]` deasserts on edge t0+RESET_HOLD+i*STAGGER.
  - State is HOLD until channel 0 releases, then RELEASE until the last channel releases.
  - With STAGGER=0 or NUM_CHANNELS=1, RELEASE is skipped and the FSM goes HOLD -> RUN.
- RUN entry: on the edge the last channel releases. `cycle_count` and the watchdog start at 0.
- RUN, per edge, in priority order:
  1. `halt_i`=1 -> DONE and `done`<=1. Halt wins over a simultaneous watchdog expiry.
  2. Else if watchdog == TIMEOUT_CYCLES-1 and `kick_i`=0 -> TIMEOUT and `timeout`<=1.
  3. Else stay in RUN. Watchdog clears to 0 if `kick_i`=1, otherwise increments.
  - `cycle_count` increments on every RUN edge, including the exit edge.
  - `cycle_count` saturates at all-ones; it does not wrap.
- DONE/TIMEOUT:
  - Terminal. `core_reset` stays released; counters freeze.
  - `halt_i` and `kick_i` are ignored.
  - Only `reset` leaves these states.
- Mid-run reset: asserting `reset` in any state immediately forces all reset values, including sticky flags and all `core_reset`=1.
- Inputs outside RUN: `halt_i` and `kick_i` are ignored in RESET, HOLD and RELEASE.
- Elaboration checks: parameter bounds violated -> `$error` at elaboration.

Decomposition:
- Package `sim_ctrl_pkg`:
  - state enum localparams: ST_RESET, ST_HOLD, ST_RELEASE, ST_RUN, ST_DONE, ST_TIMEOUT;
  - state width localparam `ST_W`=3.
- Sub-module `reset_sync`: 2-flop async-assert/sync-deassert synchroniser, ports `clk`, `reset`, `rst_s`. Reusable for other clock-domain blocks.
- Release schedule: computed in the parent via a generate loop comparing the phase counter with RESET_HOLD+i*STAGGER.

Test Plan:
- Defaults; `reset`=1 for 3 cycles, then 0 -> `rst_s` falls 2 edges later; `core_reset`: 2'b11 -> 2'b10 at t0+2 -> 2'b00 at t0+3; `state_o` = 1, 2, 3.
- Defaults; `kick_i` pulsed every 10 cycles, `halt_i` raised at RUN cycle 40 -> `state_o`=4, `done`=1, `cycle_count`=41 frozen; `core_reset` stays 0.
- TIMEOUT_CYCLES=8; no kicks in RUN -> TIMEOUT on the 8th RUN edge; `timeout`=1, `cycle_count`=8.
- TIMEOUT_CYCLES=8; `halt_i` and watchdog expiry on the same edge -> DONE, `timeout` stays 0.
- NUM_CHANNELS=4, STAGGER=0, RESET_HOLD=3 -> all four channels release together at t0+3; RELEASE never visited.
- Reset asserted mid-RUN at cycle 20 -> same cycle `core_reset`=4'hF (all ones), `cycle_count`=0, `state_o`=0; full sequence repeats after release.
